// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared types and constants for the pipeline front end.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Fetch controller states: IDLE issues, WAIT has one request in flight,
  // HOLD parks a stalled response, KILL drains a request made stale by a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 - the canonical bubble instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Owns the PC, issues in-order single-outstanding instruction
//             memory requests, and presents PCF/InstrF/PCPlus4F/ValidF to the
//             F/D register, honouring StallF and Execute redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ValidF
);

  localparam logic [DATA_WIDTH-1:0] c_pc_step    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] c_align_mask = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] c_nop        = DATA_WIDTH'(NOP_INSTR);

  fetch_state_t          r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_hold_pc;
  logic [DATA_WIDTH-1:0] r_hold_instr;

  fetch_state_t          w_next_state;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_req;
  logic [DATA_WIDTH-1:0] w_addr;
  logic                  w_deliver;
  logic [DATA_WIDTH-1:0] w_del_pc;
  logic [DATA_WIDTH-1:0] w_del_instr;
  logic                  w_hold_load;

  assign w_pc_plus4 = r_pc + c_pc_step;
  assign w_target   = PCTargetE & c_align_mask;
  assign imem_req   = w_req;
  assign imem_addr  = w_addr;

  // Next state, next PC, request generation and delivery selection.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_req        = 1'b0;
    w_addr       = r_pc;
    w_deliver    = 1'b0;
    w_del_pc     = r_pc;
    w_del_instr  = imem_rdata;
    w_hold_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (PCSrcE) begin
          // The request that would have issued is already stale; suppress it.
          w_next_pc = w_target;
        end else begin
          w_req        = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (PCSrcE) begin
          w_next_pc    = w_target;
          w_next_state = imem_rvalid ? IDLE : KILL;
        end else if (imem_rvalid && !StallF) begin
          // Accept and immediately chain the next sequential request.
          w_deliver = 1'b1;
          w_next_pc = w_pc_plus4;
          w_req     = 1'b1;
          w_addr    = w_pc_plus4;
        end else if (imem_rvalid) begin
          w_hold_load  = 1'b1;
          w_next_pc    = w_pc_plus4;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          w_next_pc    = w_target;
          w_next_state = IDLE;
        end else if (!StallF) begin
          w_deliver    = 1'b1;
          w_del_pc     = r_hold_pc;
          w_del_instr  = r_hold_instr;
          w_req        = 1'b1;
          w_next_state = WAIT;
        end
      end
      KILL: begin
        // A further redirect only updates the target; if the stale response
        // lands in that same cycle it is consumed here, so there is nothing
        // left to drain and waiting on in KILL would never end.
        if (PCSrcE) begin
          w_next_pc = w_target;
        end
        if (imem_rvalid) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Controller state, PC, hold buffer and the F/D-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      PCF          <= '0;
      InstrF       <= c_nop;
      PCPlus4F     <= '0;
      ValidF       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (PCSrcE) begin
        r_hold_pc    <= '0;
        r_hold_instr <= '0;
      end else if (w_hold_load) begin
        r_hold_pc    <= r_pc;
        r_hold_instr <= imem_rdata;
      end
      if (PCSrcE) begin
        ValidF <= 1'b0;
        InstrF <= c_nop;
      end else if (w_deliver) begin
        PCF      <= w_del_pc;
        InstrF   <= w_del_instr;
        PCPlus4F <= w_del_pc + c_pc_step;
        ValidF   <= 1'b1;
      end else if (!StallF) begin
        ValidF <= 1'b0;
        InstrF <= c_nop;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage with a latency-configurable
//             instruction memory returning addr ^ 32'hA5A5A5A5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PCF, InstrF, PCPlus4F;
  logic        ValidF;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int overlap_err = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit mem_pend = 1'b0;
  int mem_due = 0;
  logic [31:0] mem_addr = '0;

  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] o_pc, o_instr, o_pc4, p_pc, p_instr, p_pc4;
  logic        o_valid, p_valid;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PCF(PCF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .ValidF(ValidF)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock cycle: drive inputs mid-cycle, let the memory model react to
  // the combinational request, then capture registered outputs after the edge.
  task automatic step(input logic stall, input logic src, input logic [31:0] tgt, input logic r);
    rst = r; StallF = stall; PCSrcE = src; PCTargetE = tgt;
    imem_rvalid = mem_pend && (cyc >= mem_due);
    imem_rdata  = imem_rvalid ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    s_req = imem_req; s_addr = imem_addr;
    if (r) mem_pend = 1'b0;
    else begin
      if (imem_rvalid) mem_pend = 1'b0;
      if (imem_req) begin
        if (mem_pend) overlap_err++;
        mem_pend = 1'b1;
        mem_due  = cyc + int'($urandom_range(lat_max, lat_min));
        mem_addr = imem_addr;
      end
    end
    p_pc = o_pc; p_instr = o_instr; p_pc4 = o_pc4; p_valid = o_valid;
    @(posedge clk); #1;
    cyc++;
    o_pc = PCF; o_instr = InstrF; o_pc4 = PCPlus4F; o_valid = ValidF;
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat);
    lat_min = lat; lat_max = lat;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_reset;
    do_reset(1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", o_instr, NOP); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    checks++; if (o_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", o_pc4); end
    step(0, 0, 0, 0);
    checks++; if (s_req !== 1'b1 || s_addr !== RPC) begin errors++; $display("FAIL first_req: req %b addr %h want 1 %h", s_req, s_addr, RPC); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b want 0", o_valid); end
    step(0, 0, 0, 0);
    checks++; if (s_addr !== 32'h4) begin errors++; $display("FAIL chained_req: got %h want 4", s_addr); end
    checks++; if (o_valid !== 1'b1 || o_pc !== RPC || o_instr !== (RPC ^ KEY) || o_pc4 !== RPC + 4) begin
      errors++; $display("FAIL first_instr: v %b pc %h instr %h pc4 %h", o_valid, o_pc, o_instr, o_pc4); end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'(4 * i) || o_instr !== (32'(4 * i) ^ KEY)) begin
        errors++; $display("FAIL stream_%0d: v %b pc %h instr %h want pc %h", i, o_valid, o_pc, o_instr, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall;
    do_reset(1);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== (32'h4 ^ KEY)) begin
        errors++; $display("FAIL stall_hold_%0d: v %b pc %h instr %h want pc 4", i, o_valid, o_pc, o_instr); end
      if (i > 0) begin
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_no_req_%0d: got %b want 0", i, s_req); end
      end
    end
    step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== (32'h8 ^ KEY)) begin
      errors++; $display("FAIL stall_release: v %b pc %h instr %h want pc 8", o_valid, o_pc, o_instr); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'hC) begin errors++; $display("FAIL stall_next_req: req %b addr %h want 1 c", s_req, s_addr); end
    step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'hC) begin errors++; $display("FAIL stall_after: v %b pc %h want c", o_valid, o_pc); end
  endtask

  task automatic test_redirect_wait;
    do_reset(4);
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    checks++; if (s_req !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL rw_redirect: req %b v %b want 0 0", s_req, o_valid); end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    lat_min = 1; lat_max = 1;
    step(0, 0, 0, 0);
    checks++; if (s_req !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL rw_drop: req %b v %b want 0 0", s_req, o_valid); end
    step(0, 0, 0, 0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL rw_target_req: req %b addr %h want 1 100", s_req, s_addr); end
    step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== (32'h100 ^ KEY)) begin
      errors++; $display("FAIL rw_target_instr: v %b pc %h instr %h", o_valid, o_pc, o_instr); end
  endtask

  task automatic test_redirect_hold;
    do_reset(1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL rh_hold: v %b pc %h want 1 0", o_valid, o_pc); end
    step(1, 1, 32'h200, 0);
    checks++; if (o_valid !== 1'b0 || o_instr !== NOP || s_req !== 1'b0) begin
      errors++; $display("FAIL rh_redirect: v %b instr %h req %b", o_valid, o_instr, s_req); end
    step(0, 0, 0, 0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200 || o_valid !== 1'b0) begin
      errors++; $display("FAIL rh_resume_req: req %b addr %h v %b", s_req, s_addr, o_valid); end
    step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instr !== (32'h200 ^ KEY)) begin
      errors++; $display("FAIL rh_resume_instr: v %b pc %h instr %h", o_valid, o_pc, o_instr); end
  endtask

  task automatic test_align_wrap;
    do_reset(1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h103, 0);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL aw_suppress: got %b want 0", s_req); end
    step(0, 0, 0, 0);
    checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL aw_align_addr: got %h want 100", s_addr); end
    step(0, 0, 0, 0);
    checks++; if (o_pc !== 32'h100 || s_addr !== 32'h104) begin errors++; $display("FAIL aw_align_pc: pc %h addr %h", o_pc, s_addr); end
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    checks++; if (s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL aw_top_addr: got %h want fffffffc", s_addr); end
    step(0, 0, 0, 0);
    checks++; if (o_pc !== 32'hFFFF_FFFC || o_pc4 !== 32'h0 || s_addr !== 32'h0) begin
      errors++; $display("FAIL aw_wrap: pc %h pc4 %h addr %h", o_pc, o_pc4, s_addr); end
    step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== KEY) begin
      errors++; $display("FAIL aw_after_wrap: v %b pc %h instr %h", o_valid, o_pc, o_instr); end
  endtask

  task automatic test_reset_mid;
    do_reset(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h4) begin errors++; $display("FAIL rm_pre: v %b pc %h want 1 4", o_valid, o_pc); end
    step(0, 0, 0, 1);
    checks++; if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_pc4 !== 32'h0 || o_instr !== NOP) begin
      errors++; $display("FAIL rm_reset_vals: v %b pc %h pc4 %h instr %h", o_valid, o_pc, o_pc4, o_instr); end
    step(0, 0, 0, 0);
    checks++; if (s_req !== 1'b1 || s_addr !== RPC) begin errors++; $display("FAIL rm_req: req %b addr %h", s_req, s_addr); end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    checks++; if (o_valid !== 1'b1 || o_pc !== RPC) begin errors++; $display("FAIL rm_first: v %b pc %h", o_valid, o_pc); end
  endtask

  // Random traffic against a stream-level model: requests and deliveries must
  // each walk sequential PCs from the last reset/redirect, with no gaps or repeats.
  task automatic test_random;
    logic [31:0] exp_pc, req_exp, tgt;
    logic stall, src, r;
    int deliveries;
    do_reset(1);
    lat_min = 1; lat_max = 3;
    exp_pc = RPC; req_exp = RPC; deliveries = 0;
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      src   = ($urandom_range(0, 19) == 0);
      r     = ($urandom_range(0, 99) == 0);
      tgt   = $urandom;
      step(stall, src, tgt, r);
      if (r) begin
        checks++; if (o_valid !== 1'b0 || o_instr !== NOP || o_pc !== 32'h0 || o_pc4 !== 32'h0) begin
          errors++; $display("FAIL rnd_reset@%0d: v %b pc %h instr %h", i, o_valid, o_pc, o_instr); end
        exp_pc = RPC; req_exp = RPC;
      end else begin
        if (src) begin
          checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rnd_req_on_redirect@%0d: got %b want 0", i, s_req); end
          req_exp = tgt & ~32'h3;
        end else if (s_req === 1'b1) begin
          checks++; if (s_addr !== req_exp) begin errors++; $display("FAIL rnd_req_addr@%0d: got %h want %h", i, s_addr, req_exp); end
          req_exp = req_exp + 32'h4;
        end
        if (src) begin
          checks++; if (o_valid !== 1'b0 || o_instr !== NOP || o_pc !== p_pc || o_pc4 !== p_pc4) begin
            errors++; $display("FAIL rnd_redirect_out@%0d: v %b instr %h pc %h want pc %h", i, o_valid, o_instr, o_pc, p_pc); end
          exp_pc = tgt & ~32'h3;
        end else if (stall) begin
          checks++; if (o_valid !== p_valid || o_instr !== p_instr || o_pc !== p_pc || o_pc4 !== p_pc4) begin
            errors++; $display("FAIL rnd_stall_hold@%0d: v %b pc %h want v %b pc %h", i, o_valid, o_pc, p_valid, p_pc); end
        end else if (o_valid === 1'b1) begin
          checks++; if (o_pc !== exp_pc || o_instr !== (exp_pc ^ KEY) || o_pc4 !== exp_pc + 32'h4) begin
            errors++; $display("FAIL rnd_deliver@%0d: pc %h instr %h pc4 %h want pc %h", i, o_pc, o_instr, o_pc4, exp_pc); end
          exp_pc = exp_pc + 32'h4;
          deliveries++;
        end else begin
          checks++; if (o_instr !== NOP || o_pc !== p_pc || o_pc4 !== p_pc4 || o_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_bubble@%0d: v %b instr %h pc %h want pc %h", i, o_valid, o_instr, o_pc, p_pc); end
        end
      end
    end
    checks++; if (overlap_err !== 0) begin errors++; $display("FAIL rnd_outstanding: got %0d overlaps want 0", overlap_err); end
    checks++; if (deliveries < 60) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 60", deliveries); end
  endtask

  initial begin
    o_pc = '0; o_instr = '0; o_pc4 = '0; o_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_align_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
